alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs a 1..MAX_BYTES byte add/sub/and/orr/xor/cmp through an
// 8-bit ALU, one byte per cycle, and assembles the result and final flags.
// Ports: clk, rst (sync, active-high); start/req_* request; alu_* drive to
// and return from the ALU; busy/done/err status; result, flags_out outputs.

package pkg_alu;
    typedef enum logic [2:0] {
        alu_op_add, alu_op_adc, alu_op_sub, alu_op_sbc,
        alu_op_and, alu_op_orr, alu_op_xor, alu_op_cmp
    } alu_oper;

    typedef struct packed {
        logic [3:0] rsv;
        logic       n;
        logic       v;
        logic       z;
        logic       c;
    } proc_flags;
endpackage

module alu_seq_ctrl #(
    parameter int MAX_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             req_op,
    input  logic [2:0]             req_len,
    input  logic [8*MAX_BYTES-1:0] req_a,
    input  logic [8*MAX_BYTES-1:0] req_b,
    input  pkg_alu::proc_flags     flags_in,
    output pkg_alu::alu_oper       alu_oper,
    output logic [7:0]             alu_a_lo,
    output logic [7:0]             alu_a_hi,
    output logic [7:0]             alu_b,
    output pkg_alu::proc_flags     alu_flags_in,
    input  logic [7:0]             alu_out_lo,
    input  pkg_alu::proc_flags     alu_flags_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [8*MAX_BYTES-1:0] result,
    output pkg_alu::proc_flags     flags_out
);
    localparam int W = 8 * MAX_BYTES;
    localparam logic [2:0] MAX_LEN = 3'(MAX_BYTES);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, len_q, idx_q;
    logic [W-1:0]       a_q, b_q, result_q;
    pkg_alu::proc_flags flags_q, flags_out_q, flags_fin;
    logic               carry_q, z_acc_q, err_q;
    logic               legal, accept, reject, first, last;
    logic               unused_flags;

    assign legal = (req_op <= OP_CMP) && (req_len != 3'd0)
                   && (req_len <= MAX_LEN);
    assign first = (idx_q == 3'd0);
    assign last  = (idx_q == len_q - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU drive; first byte uses the non-carry op and the captured C,
    // later bytes chain the carry produced by the previous byte.
    always_comb begin
        alu_oper     = pkg_alu::alu_op_add;
        alu_a_lo     = 8'h00;
        alu_b        = 8'h00;
        alu_flags_in = flags_in;
        if (state_q == RUN) begin
            alu_a_lo     = 8'(a_q >> (8 * idx_q));
            alu_b        = 8'(b_q >> (8 * idx_q));
            alu_flags_in = flags_q;
            if (!first) alu_flags_in.c = carry_q;
            unique case (op_q)
                OP_ADD: alu_oper = first ? pkg_alu::alu_op_add
                                         : pkg_alu::alu_op_adc;
                OP_SUB: alu_oper = first ? pkg_alu::alu_op_sub
                                         : pkg_alu::alu_op_sbc;
                OP_CMP: alu_oper = first ? pkg_alu::alu_op_cmp
                                         : pkg_alu::alu_op_sbc;
                OP_AND: alu_oper = pkg_alu::alu_op_and;
                OP_ORR: alu_oper = pkg_alu::alu_op_orr;
                OP_XOR: alu_oper = pkg_alu::alu_op_xor;
                default: alu_oper = pkg_alu::alu_op_add;
            endcase
        end
    end

    // Final flags: captured flags with only C and Z taken from the run.
    always_comb begin
        flags_fin   = flags_q;
        flags_fin.c = alu_flags_out.c;
        flags_fin.z = z_acc_q & alu_flags_out.z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 3'd0;
            len_q       <= 3'd0;
            idx_q       <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            flags_q     <= '0;
            carry_q     <= 1'b0;
            z_acc_q     <= 1'b1;
            result_q    <= '0;
            flags_out_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                op_q     <= req_op;
                len_q    <= req_len;
                a_q      <= req_a;
                b_q      <= req_b;
                flags_q  <= flags_in;
                idx_q    <= 3'd0;
                z_acc_q  <= 1'b1;
                result_q <= '0;
            end else if (state_q == RUN) begin
                carry_q <= alu_flags_out.c;
                z_acc_q <= z_acc_q & alu_flags_out.z;
                idx_q   <= idx_q + 3'd1;
                // result was cleared on accept, so OR-ing places byte i
                if (op_q != OP_CMP) begin
                    result_q <= result_q
                                | (W'(alu_out_lo) << (8 * idx_q));
                end
                if (last) flags_out_q <= flags_fin;
            end
        end
    end

    assign unused_flags = ^{alu_flags_out.rsv, alu_flags_out.n,
                            alu_flags_out.v};

    assign alu_a_hi  = 8'h00;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: drives alu_seq_ctrl with an 8-bit ALU model and checks
// it against whole-word arithmetic computed from the operation rules.
module tb_alu_seq_ctrl;
    localparam int MB = 4;

    logic               clk = 1'b0;
    logic               rst, start;
    logic [2:0]         req_op, req_len;
    logic [8*MB-1:0]    req_a, req_b, result;
    pkg_alu::proc_flags flags_in, alu_flags_in, alu_flags_out, flags_out;
    pkg_alu::alu_oper   alu_oper;
    logic [7:0]         alu_a_lo, alu_a_hi, alu_b, alu_out_lo;
    logic               busy, done, err;
    logic [8:0]         alu_sum;

    int tests = 0;
    int fails = 0;
    logic [31:0]        last_result;
    pkg_alu::proc_flags last_flags;

    alu_seq_ctrl #(.MAX_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .start(start), .req_op(req_op),
        .req_len(req_len), .req_a(req_a), .req_b(req_b),
        .flags_in(flags_in), .alu_oper(alu_oper), .alu_a_lo(alu_a_lo),
        .alu_a_hi(alu_a_hi), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
        .alu_out_lo(alu_out_lo), .alu_flags_out(alu_flags_out),
        .busy(busy), .done(done), .err(err), .result(result),
        .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    // 8-bit ALU: subtract is a + ~b + cin (C=1 means no borrow);
    // N, V and reserved bits are scrambled so only C/Z may be used.
    always_comb begin
        alu_sum = 9'd0;
        case (alu_oper)
            pkg_alu::alu_op_add: alu_sum = {1'b0, alu_a_lo} + {1'b0, alu_b};
            pkg_alu::alu_op_adc: alu_sum = {1'b0, alu_a_lo} + {1'b0, alu_b}
                                           + {8'd0, alu_flags_in.c};
            pkg_alu::alu_op_sub,
            pkg_alu::alu_op_cmp: alu_sum = {1'b0, alu_a_lo} + {1'b0, ~alu_b}
                                           + 9'd1;
            pkg_alu::alu_op_sbc: alu_sum = {1'b0, alu_a_lo} + {1'b0, ~alu_b}
                                           + {8'd0, alu_flags_in.c};
            pkg_alu::alu_op_and: alu_sum = {alu_flags_in.c, alu_a_lo & alu_b};
            pkg_alu::alu_op_orr: alu_sum = {alu_flags_in.c, alu_a_lo | alu_b};
            pkg_alu::alu_op_xor: alu_sum = {alu_flags_in.c, alu_a_lo ^ alu_b};
            default:             alu_sum = 9'd0;
        endcase
        alu_out_lo        = alu_sum[7:0];
        alu_flags_out     = alu_flags_in;
        alu_flags_out.c   = alu_sum[8];
        alu_flags_out.z   = (alu_sum[7:0] == 8'h00);
        alu_flags_out.n   = alu_sum[7];
        alu_flags_out.v   = ~alu_flags_in.v;
        alu_flags_out.rsv = ~alu_flags_in.rsv;
    end

    function automatic pkg_alu::alu_oper exp_op(input logic [2:0] op,
                                                input int i);
        case (op)
            3'd0:    return (i == 0) ? pkg_alu::alu_op_add : pkg_alu::alu_op_adc;
            3'd1:    return (i == 0) ? pkg_alu::alu_op_sub : pkg_alu::alu_op_sbc;
            3'd5:    return (i == 0) ? pkg_alu::alu_op_cmp : pkg_alu::alu_op_sbc;
            3'd2:    return pkg_alu::alu_op_and;
            3'd3:    return pkg_alu::alu_op_orr;
            default: return pkg_alu::alu_op_xor;
        endcase
    endfunction

    // Carry out of the low n bytes of the word operation.
    function automatic logic carry_low(input logic [2:0] op, input int n,
                                       input logic [31:0] a, b,
                                       input logic fc);
        logic [39:0] m, s;
        m = (40'd1 << (8 * n)) - 40'd1;
        s = ({8'd0, a} & m) + ({8'd0, b} & m);
        case (op)
            3'd0:       return s[8*n];
            3'd1, 3'd5: return ({8'd0, a} & m) >= ({8'd0, b} & m);
            default:    return fc;
        endcase
    endfunction

    task automatic run_req(input string name, input logic [2:0] op,
                           input logic [2:0] len, input logic [31:0] a, b,
                           input pkg_alu::proc_flags f, input bit noise);
        logic [39:0] m, r;
        logic [31:0] am, bm;
        pkg_alu::proc_flags ef, fi;
        m  = (40'd1 << (8 * len)) - 40'd1;
        am = 32'({8'd0, a} & m);
        bm = 32'({8'd0, b} & m);
        case (op)
            3'd0:    r = ({8'd0, am} + {8'd0, bm}) & m;
            3'd1:    r = ({8'd0, am} - {8'd0, bm}) & m;
            3'd2:    r = {8'd0, am & bm};
            3'd3:    r = {8'd0, am | bm};
            3'd4:    r = {8'd0, am ^ bm};
            default: r = 40'd0;
        endcase
        ef   = f;
        ef.c = carry_low(op, int'(len), am, bm, f.c);
        ef.z = (op == 3'd5) ? (am == bm) : (r == 40'd0);

        start = 1'b1; req_op = op; req_len = len;
        req_a = a; req_b = b; flags_in = f;
        @(negedge clk);
        for (int i = 0; i < int'(len); i++) begin
            if (noise) begin
                req_op = 3'($urandom_range(0, 7));
                req_len = 3'($urandom_range(0, 7));
                req_a = $urandom; req_b = $urandom;
                flags_in = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            fi = f;
            if (i > 0) fi.c = carry_low(op, i, am, bm, f.c);
            tests++;
            if (alu_oper !== exp_op(op, i)) begin
                fails++;
                $display("FAIL %s op[%0d]: got %0d want %0d",
                         name, i, alu_oper, exp_op(op, i));
            end
            tests++;
            if ({alu_a_hi, alu_a_lo, alu_b} !== {8'h00, am[8*i +: 8], bm[8*i +: 8]}) begin
                fails++;
                $display("FAIL %s operands[%0d]: got %h want %h", name, i,
                         {alu_a_hi, alu_a_lo, alu_b},
                         {8'h00, am[8*i +: 8], bm[8*i +: 8]});
            end
            tests++;
            if (alu_flags_in !== fi) begin
                fails++;
                $display("FAIL %s alu_flags_in[%0d]: got %h want %h",
                         name, i, alu_flags_in, fi);
            end
            tests++;
            if ({busy, done, err} !== 3'b100) begin
                fails++;
                $display("FAIL %s run status[%0d]: got %b want 100",
                         name, i, {busy, done, err});
            end
            @(negedge clk);
        end
        if (noise) begin
            start = 1'b1;
            req_op = 3'($urandom_range(0, 5));
            req_len = 3'($urandom_range(1, 4));
        end
        tests++;
        if ({busy, done} !== 2'b11) begin
            fails++;
            $display("FAIL %s done status: got %b want 11", name, {busy, done});
        end
        tests++;
        if ({result, flags_out} !== {r[31:0], ef}) begin
            fails++;
            $display("FAIL %s result/flags: got %h/%h want %h/%h",
                     name, result, flags_out, r[31:0], ef);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, done, result, flags_out} !== {2'b00, r[31:0], ef}) begin
            fails++;
            $display("FAIL %s idle hold: got %b %h/%h want 00 %h/%h", name,
                     {busy, done}, result, flags_out, r[31:0], ef);
        end
        tests++;
        if ({alu_oper, alu_a_lo, alu_b, alu_flags_in} !==
            {pkg_alu::alu_op_add, 16'h0000, flags_in}) begin
            fails++;
            $display("FAIL %s idle alu drive: got %0d %h %h %h", name,
                     alu_oper, alu_a_lo, alu_b, alu_flags_in);
        end
        last_result = r[31:0];
        last_flags  = ef;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; req_op = 3'd0; req_len = 3'd2;
        req_a = 32'h1111_1111; req_b = 32'h2222_2222; flags_in = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({busy, done, err, result, flags_out} !== {3'b000, 32'h0, 8'h00}) begin
            fails++;
            $display("FAIL reset state: got %b %h %h",
                     {busy, done, err}, result, flags_out);
        end
        tests++;
        if ({alu_oper, alu_a_lo, alu_b, alu_flags_in} !==
            {pkg_alu::alu_op_add, 16'h0000, 8'h5A}) begin
            fails++;
            $display("FAIL reset alu drive: got %0d %h %h %h",
                     alu_oper, alu_a_lo, alu_b, alu_flags_in);
        end
        rst = 1'b0; start = 1'b0;
        last_result = 32'h0;
        last_flags  = '0;
    endtask

    task automatic test_directed;
        pkg_alu::proc_flags f;
        f = 8'hA4; f.c = 1'b0;
        run_req("add2", 3'd0, 3'd2, 32'h0000_00FF, 32'h0000_0001, f, 1'b0);
        run_req("sub4", 3'd1, 3'd4, 32'h0, 32'h1, f, 1'b0);
        run_req("cmp2", 3'd5, 3'd2, 32'h1234, 32'h1234, f, 1'b0);
        f.c = 1'b1;
        run_req("xor3", 3'd4, 3'd3, 32'hABCDEF, 32'hABCDEF, f, 1'b0);
        run_req("and1", 3'd2, 3'd1, 32'hFFFF_FF3C, 32'hFFFF_FF0F, f, 1'b0);
    endtask

    task automatic test_illegal;
        logic [2:0] bad_op [4];
        logic [2:0] bad_len [4];
        bad_op  = '{3'd0, 3'd6, 3'd1, 3'd7};
        bad_len = '{3'd0, 3'd2, 3'd5, 3'd3};
        for (int k = 0; k < 4; k++) begin
            start = 1'b1; req_op = bad_op[k]; req_len = bad_len[k];
            req_a = $urandom; req_b = $urandom; flags_in = 8'($urandom);
            @(negedge clk);
            start = 1'b0;
            tests++;
            if ({err, busy, result, flags_out} !==
                {2'b10, last_result, last_flags}) begin
                fails++;
                $display("FAIL illegal[%0d]: got %b %h/%h want 10 %h/%h", k,
                         {err, busy}, result, flags_out,
                         last_result, last_flags);
            end
            @(negedge clk);
            tests++;
            if ({err, busy} !== 2'b00) begin
                fails++;
                $display("FAIL illegal[%0d] pulse: got %b want 00",
                         k, {err, busy});
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int seen_done;
        start = 1'b1; req_op = 3'd0; req_len = 3'd4;
        req_a = $urandom; req_b = $urandom; flags_in = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({busy, done, result, flags_out} !== {2'b00, 32'h0, 8'h00}) begin
            fails++;
            $display("FAIL midrun reset: got %b %h/%h",
                     {busy, done}, result, flags_out);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        tests++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL midrun no_done: got %0d pulses want 0", seen_done);
        end
        last_result = 32'h0;
        last_flags  = '0;
        run_req("after_rst", 3'd0, 3'd4, 32'h89AB_CDEF, 32'h7654_3211,
                8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_req("b2b_a", 3'd0, 3'd1, 32'h0000_00FF, 32'h0000_0001, 8'h00, 1'b0);
        run_req("b2b_b", 3'd3, 3'd4, 32'hF0F0_0000, 32'h0F0F_0001, 8'h00, 1'b1);
        run_req("b2b_c", 3'd1, 3'd1, 32'h0000_0005, 32'h0000_0005, 8'h00, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            run_req("rand", 3'($urandom_range(0, 5)),
                    3'($urandom_range(1, MB)), $urandom, $urandom,
                    8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; req_op = 3'd0; req_len = 3'd0;
        req_a = '0; req_b = '0; flags_in = '0;
        test_reset();
        test_directed();
        test_illegal();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
